dip_switch_ctrl: RTL

Parametrised, debounced DIP-switch input peripheral for the bridge-attached device bus. It samples NUM_BANKS banks of BANK_W switch lines and synchronises and debounces each bank. It presents the polarity-corrected switch state as 32-bit read words and records per-bit sticky change flags, which can raise a maskable interrupt toward the CP0 hardware-interrupt inputs.

---
 rtl/dip_switch_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/dip_switch_ctrl.sv
// Debounced DIP-switch input peripheral for the device bus.
// Presents polarity-corrected switch state, sticky change flags and an IRQ.
module dip_switch_ctrl #(
    parameter int NUM_BANKS       = 8,
    parameter int BANK_W          = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 Addr,
    input  logic                        WE,
    input  logic [31:0]                 WD,
    input  logic [NUM_BANKS*BANK_W-1:0] In,
    output logic [31:0]                 RD,
    output logic                        IRQ
);
    localparam int N         = NUM_BANKS * BANK_W;
    localparam int NUM_WORDS = N / 32;
    localparam int CW        = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [N-1:0]  IDLE    = {N{ACTIVE_LOW}};
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]           sync1_q, sync2_q;
    logic [N-1:0]           cand_q, cand_d;
    logic [N-1:0]           stab_q, stab_d;
    logic [N-1:0]           chg_q, chg_d, clr;
    logic [NUM_BANKS*CW-1:0] cnt_q, cnt_d;
    logic                   ien_q, ien_d;
    logic [4:0]             idx;
    logic [N-1:0]           data;
    logic                   unused_addr;

    assign idx         = Addr[6:2];
    assign unused_addr = ^{Addr[31:7], Addr[1:0]};
    assign data        = stab_q ^ IDLE;
    assign IRQ         = ien_q & (|chg_q);

    // Each bank restarts its window whenever the synchronised value moves.
    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        cnt_d  = cnt_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (sync2_q[b*BANK_W +: BANK_W] != cand_q[b*BANK_W +: BANK_W]) begin
                cand_d[b*BANK_W +: BANK_W] = sync2_q[b*BANK_W +: BANK_W];
                cnt_d[b*CW +: CW]          = '0;
            end else if (cnt_q[b*CW +: CW] == CNT_MAX) begin
                stab_d[b*BANK_W +: BANK_W] = cand_q[b*BANK_W +: BANK_W];
            end else begin
                cnt_d[b*CW +: CW] = cnt_q[b*CW +: CW] + CW'(1);
            end
        end
    end

    always_comb begin
        clr   = '0;
        ien_d = ien_q;
        if (WE) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (idx == 5'(4 + k)) clr[32*k +: 32] = WD;
            end
            if (idx == 5'd8) ien_d = WD[0];
        end
        // A new toggle outranks a clear on the same edge.
        chg_d = (chg_q & ~clr) | (stab_d ^ stab_q);
    end

    always_comb begin
        RD = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx == 5'(k))     RD = data[32*k +: 32];
            if (idx == 5'(4 + k)) RD = chg_q[32*k +: 32];
        end
        if (idx == 5'd8) RD = {31'd0, ien_q};
        if (idx == 5'd9) RD = {31'd0, |chg_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
            cand_q  <= IDLE;
            stab_q  <= IDLE;
            cnt_q   <= '0;
            chg_q   <= '0;
            ien_q   <= 1'b0;
        end else begin
            sync1_q <= In;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
            ien_q   <= ien_d;
        end
    end
endmodule
